// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: bus widths, the memory response record and
// the byte-address to word-index helper used by the instruction and data memories.
package mips_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } resp_t;

  // Full-width word index; callers compare it against their depth before truncating.
  function automatic logic [ADDR_W-1:0] addr_to_word_index(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides;
// pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_fire, rd_fire;

  assign rd_valid = (wr_ptr_q != rd_ptr_q);
  assign wr_ready = !((wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]));
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;
  assign rd_data  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (rd_fire) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency synchronous reads, in-order responses
// through a credit-limited FIFO, plus a side load port for program words.
module imem_responder #(
  parameter int ADDR_W      = mips_pkg::ADDR_W,
  parameter int DATA_W      = mips_pkg::DATA_W,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  import mips_pkg::*;

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int RW    = DATA_W + ADDR_W + 1;

  logic [DATA_W-1:0]  mem [DEPTH_WORDS];
  logic [ADDR_W-1:0]  req_word, ld_word;
  logic               req_err, accept, deliver;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [ADDR_W-1:0]  addr_q [LATENCY];
  logic [ADDR_W-1:0]  addr_d [LATENCY];
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic               fifo_wr_ready, fifo_rd_valid;
  logic [RW-1:0]      fifo_wr_data, fifo_rd_data;

  assign req_word  = addr_to_word_index(req_addr);
  assign ld_word   = addr_to_word_index(ld_addr);
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_word >= ADDR_W'(DEPTH_WORDS));
  assign req_ready = (cnt_q < CNT_W'(QDEPTH));
  assign accept    = req_valid && req_ready;
  assign deliver   = fifo_rd_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (ld_en && (ld_word < ADDR_W'(DEPTH_WORDS))) mem[ld_word[IDX_W-1:0]] <= ld_data;
  end

  always_comb begin
    vld_d     = vld_q;
    err_d     = err_q;
    addr_d    = addr_q;
    vld_d[0]  = accept;
    err_d[0]  = req_err;
    addr_d[0] = req_addr;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      err_d[i]  = err_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !deliver)      cnt_d = cnt_q + CNT_W'(1);
    else if (!accept && deliver) cnt_d = cnt_q - CNT_W'(1);
  end

  // The read data register doubles as stage 0 of the data pipe, so the memory
  // stays a plain read-first synchronous RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
    err_q    <= err_d;
    addr_q   <= addr_d;
    dat_q[0] <= mem[req_word[IDX_W-1:0]];
    for (int i = 1; i < LATENCY; i++) dat_q[i] <= dat_q[i-1];
  end

  assign fifo_wr_data = {(err_q[LATENCY-1] ? {DATA_W{1'b0}} : dat_q[LATENCY-1]),
                         addr_q[LATENCY-1], err_q[LATENCY-1]};

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (QDEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (vld_q[LATENCY-1]),
    .wr_ready (fifo_wr_ready),
    .wr_data  (fifo_wr_data),
    .rd_valid (fifo_rd_valid),
    .rd_ready (resp_ready),
    .rd_data  (fifo_rd_data)
  );

  assign resp_valid = fifo_rd_valid;
  assign {resp_data, resp_addr, resp_err} = fifo_rd_valid ? fifo_rd_data : {RW{1'b0}};

  // Credits cap in-flight plus queued entries at QDEPTH, so the FIFO can never be full on a write.
  assert property (@(posedge clk) disable iff (rst) vld_q[LATENCY-1] |-> fifo_wr_ready);

endmodule

// File: tb/tb_imem_responder.sv
// Directed scoreboard bench for imem_responder: reset, single fetch, streaming,
// backpressure, error fetches, load/read collision and mid-operation reset.
module tb_imem_responder;

  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data, resp_addr;
  logic        resp_err;
  logic        ld_en;
  logic [31:0] ld_addr, ld_data;

  int          checks   = 0;
  int          errors   = 0;
  int          hs_count = 0;
  resp_t       exp_q[$];
  logic [31:0] model_mem [256];
  logic        stalled = 1'b0;
  resp_t       held;

  always #5 clk = ~clk;

  imem_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH_WORDS (256),
    .LATENCY     (2),
    .QDEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .resp_err   (resp_err),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rr);
    req_valid  = v;
    req_addr   = a;
    resp_ready = rr;
  endtask

  task automatic loadWord(input logic [31:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic fillUntilStall(input logic [31:0] base_addr, output int acc);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, base_addr + 32'(acc * 4), 1'b0);
      if (!req_ready) break;
      tick();
      acc++;
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
  endtask

  function automatic resp_t expectedResp(input logic [31:0] a);
    resp_t r;
    r.addr = a;
    r.err  = (a[1:0] != 2'b00) || (a >= 32'h400);
    r.data = r.err ? 32'h0 : model_mem[a[9:2]];
    return r;
  endfunction

  // Inputs are stable at the falling edge, so this sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    resp_t e;
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("hold_valid", 64'(resp_valid), 64'(1));
        checkOutput("hold_data", 64'(resp_data), 64'(held.data));
        checkOutput("hold_addr", 64'(resp_addr), 64'(held.addr));
        checkOutput("hold_err", 64'(resp_err), 64'(held.err));
      end
      if (resp_valid && resp_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checkOutput("resp_with_empty_sb", 64'(resp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_data", 64'(resp_data), 64'(e.data));
          checkOutput("sb_addr", 64'(resp_addr), 64'(e.addr));
          checkOutput("sb_err", 64'(resp_err), 64'(e.err));
        end
      end
      stalled = resp_valid && !resp_ready;
      held    = '{data: resp_data, addr: resp_addr, err: resp_err};
      if (req_valid && req_ready) exp_q.push_back(expectedResp(req_addr));
      if (ld_en && (ld_addr < 32'h400)) model_mem[ld_addr[9:2]] = ld_data;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int acc;
    logic ok;
    logic [31:0] err_addrs [6];

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_req_ready", 64'(req_ready), 64'(1));
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("reset_resp_data", 64'(resp_data), 64'(0));
    checkOutput("reset_resp_addr", 64'(resp_addr), 64'(0));
    checkOutput("reset_resp_err", 64'(resp_err), 64'(0));

    $display("[TB] preload program words");
    for (int i = 0; i < 16; i++) loadWord(32'(i * 4), 32'h1000_0000 + 32'(i));
    loadWord(32'h0000_000C, 32'h2002_0005);
    loadWord(32'h0000_03FE, 32'hFFEE_0255);
    loadWord(32'h0000_0400, 32'hBAD0_BAD0);

    $display("[TB] single fetch");
    applyStimulus(1'b1, 32'h0000_000C, 1'b1);
    checkOutput("single_req_ready", 64'(req_ready), 64'(1));
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("single_lat_t0", 64'(resp_valid), 64'(0));
    tick();
    checkOutput("single_lat_t1", 64'(resp_valid), 64'(0));
    tick();
    checkOutput("single_valid", 64'(resp_valid), 64'(1));
    checkOutput("single_data", 64'(resp_data), 64'(32'h2002_0005));
    checkOutput("single_addr", 64'(resp_addr), 64'(32'h0000_000C));
    checkOutput("single_err", 64'(resp_err), 64'(0));
    tick();
    checkOutput("single_drained", 64'(resp_valid), 64'(0));

    $display("[TB] streaming");
    base = hs_count;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 1'b1);
      if (!req_ready) ok = 1'b0;
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick(); tick(); tick();
    checkOutput("stream_ready_held", 64'(ok), 64'(1));
    checkOutput("stream_back_to_back", 64'(hs_count - base), 64'(16));
    checkOutput("stream_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] backpressure");
    fillUntilStall(32'h0000_0020, acc);
    checkOutput("bp_accepted", 64'(acc), 64'(4));
    checkOutput("bp_ready_low", 64'(req_ready), 64'(0));
    tick(); tick(); tick();
    checkOutput("bp_head_valid", 64'(resp_valid), 64'(1));
    checkOutput("bp_head_addr", 64'(resp_addr), 64'(32'h0000_0020));
    checkOutput("bp_head_data", 64'(resp_data), 64'(32'h1000_0008));
    base = hs_count;
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick(); tick(); tick(); tick();
    checkOutput("bp_released", 64'(hs_count - base), 64'(4));
    checkOutput("bp_ready_back", 64'(req_ready), 64'(1));
    checkOutput("bp_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] error fetches");
    err_addrs = '{32'h0000_0010, 32'h0000_0006, 32'h0000_0400,
                  32'h0000_0014, 32'hFFFF_FFFC, 32'h0000_03FC};
    base = hs_count;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, err_addrs[i], 1'b1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick(); tick(); tick();
    checkOutput("err_count", 64'(hs_count - base), 64'(6));
    checkOutput("err_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] load collision");
    applyStimulus(1'b1, 32'h0000_0014, 1'b1);
    ld_en = 1'b1; ld_addr = 32'h0000_0014; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_en = 1'b0;
    applyStimulus(1'b1, 32'h0000_0014, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("collision_old", 64'(resp_data), 64'(32'h1000_0005));
    tick();
    checkOutput("collision_new", 64'(resp_data), 64'(32'hDEAD_BEEF));
    tick();
    checkOutput("collision_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] reset with responses outstanding");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pre_reset_valid", 64'(resp_valid), 64'(1));
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    ok = !resp_valid;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid) ok = 1'b0;
    end
    checkOutput("reset_flushed", 64'(ok), 64'(1));
    fillUntilStall(32'h0000_0030, acc);
    checkOutput("reset_credits", 64'(acc), 64'(4));
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick(); tick(); tick(); tick(); tick();
    checkOutput("final_idle", 64'(resp_valid), 64'(0));
    checkOutput("final_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
